// File: rtl/cpu_pkg.sv
// Shared constants and types for the 8-bit CPU front end.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] HALT_OP = 8'hFF;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decoder handshake and control.
interface fetch_unit_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    // Fetch unit side
    modport master (
        input  start, imem_data, ir_ready, redirect, redirect_pc,
        output imem_addr, ir, ir_pc, ir_valid, halted
    );

    // Memory / decoder / control side
    modport slave (
        output start, imem_data, ir_ready, redirect, redirect_pc,
        input  imem_addr, ir, ir_pc, ir_valid, halted
    );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: redirect-load beats increment, otherwise hold.
module pc_reg #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC; increment wraps naturally at the register width
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, fetch FSM and instruction register.
//
// state | meaning
// IDLE  | not fetching; waits for start (redirect only reloads the PC)
// FETCH | fetch mem[pc] into ir whenever the ir slot is free
// HALT  | HALT_OP fetched; no fetch until redirect
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                DATA_W   = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [DATA_W-1:0] HALT_OP  = cpu_pkg::HALT_OP
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic              halted_q, halted_d;

    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic              pc_inc;
    logic              slot_free;

    pc_reg #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pc_load),
        .load_pc(bus.redirect_pc),
        .inc    (pc_inc),
        .pc     (pc)
    );

    assign slot_free = !ir_valid_q || bus.ir_ready;

    // Next state, instruction register and PC control; redirect overrides all
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;

        // A transfer this edge empties the slot unless refilled below
        if (ir_valid_q && bus.ir_ready) begin
            ir_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (slot_free) begin
                    ir_d       = bus.imem_data;
                    ir_pc_d    = pc;
                    ir_valid_d = 1'b1;
                    if (bus.imem_data == HALT_OP) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end
            end
            HALT: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.redirect) begin
            pc_load    = 1'b1;
            pc_inc     = 1'b0;
            ir_d       = ir_q;
            ir_pc_d    = ir_pc_q;
            ir_valid_d = 1'b0;
            if (state_q != IDLE) begin
                state_d  = FETCH;
                halted_d = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // FSM and instruction register flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.ir        = ir_q;
    assign bus.ir_pc     = ir_pc_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, against a
// cycle-level reference model of the fetch rules.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    logic [7:0] mem [256];

    fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    fetch_unit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: running mode 0=idle, 1=fetching, 2=halted
    int       m_mode;
    bit [7:0] m_pc, m_ir, m_ir_pc;
    bit       m_v, m_halted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 8'h00; m_ir = 8'h00; m_ir_pc = 8'h00;
        m_v = 1'b0; m_halted = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ir_valid"}, {31'd0, bus.ir_valid}, {31'd0, m_v});
        chk({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, m_halted});
        chk({tag, ".imem_addr"}, {24'd0, bus.imem_addr}, {24'd0, m_pc});
        if (m_v) begin
            chk({tag, ".ir"}, {24'd0, bus.ir}, {24'd0, m_ir});
            chk({tag, ".ir_pc"}, {24'd0, bus.ir_pc}, {24'd0, m_ir_pc});
        end
    endtask

    // One clock: drive inputs, advance model, compare after the edge
    task automatic step(input bit st, input bit rdy, input bit rd, input bit [7:0] rpc);
        bit free;
        bus.start = st; bus.ir_ready = rdy; bus.redirect = rd; bus.redirect_pc = rpc;
        free = !m_v || rdy;
        @(posedge clk);
        if (rd) begin
            m_v  = 1'b0;
            m_pc = rpc;
            if (m_mode != 0) begin
                m_mode = 1; m_halted = 1'b0;
            end
        end else begin
            if (m_v && rdy) m_v = 1'b0;
            if (m_mode == 0) begin
                if (st) m_mode = 1;
            end else if (m_mode == 1 && free) begin
                m_ir = mem[m_pc]; m_ir_pc = m_pc; m_v = 1'b1;
                if (mem[m_pc] == 8'hFF) begin
                    m_mode = 2; m_halted = 1'b1;
                end else begin
                    m_pc = m_pc + 8'd1;
                end
            end
        end
        #1;
        check_all("cyc");
    endtask

    task automatic chk_ir(input string tag, input bit [7:0] e_ir, input bit [7:0] e_pc);
        chk({tag, ".valid"}, {31'd0, bus.ir_valid}, 32'd1);
        chk({tag, ".ir"}, {24'd0, bus.ir}, {24'd0, e_ir});
        chk({tag, ".ir_pc"}, {24'd0, bus.ir_pc}, {24'd0, e_pc});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33;
        mem[8'h03] = 8'h44; mem[8'h04] = 8'h55; mem[8'h05] = 8'hFF;
        mem[8'h80] = 8'hA5; mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02;
        bus.start = 0; bus.ir_ready = 0; bus.redirect = 0; bus.redirect_pc = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.ir", {24'd0, bus.ir}, 32'h0);
        chk("rst.ir_pc", {24'd0, bus.ir_pc}, 32'h0);
        check_all("rst");
        #12 rst_n = 1'b1;

        // Idle until start, then streaming
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("start.no_valid_yet", {31'd0, bus.ir_valid}, 32'd0);
        step(0, 1, 0, 0); chk_ir("s0", 8'h11, 8'h00);
        step(0, 1, 0, 0); chk_ir("s1", 8'h22, 8'h01);

        // Stall three cycles on 22
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk_ir("stall", 8'h22, 8'h01);
            chk("stall.addr", {24'd0, bus.imem_addr}, 32'h02);
        end
        step(0, 1, 0, 0); chk_ir("s2", 8'h33, 8'h02);
        step(0, 1, 0, 0); chk_ir("s3", 8'h44, 8'h03);

        // Redirect while stalled
        step(0, 0, 0, 0);
        step(0, 0, 1, 8'h80);
        chk("rd80.valid", {31'd0, bus.ir_valid}, 32'd0);
        chk("rd80.addr", {24'd0, bus.imem_addr}, 32'h80);
        step(0, 1, 0, 0); chk_ir("rd80.ir", 8'hA5, 8'h80);

        // Wrap FE, FF, 00 then run into the halt at 05
        mem[8'h00] = 8'h03;
        step(0, 1, 1, 8'hFE);
        step(0, 1, 0, 0); chk_ir("w0", 8'h01, 8'hFE);
        step(0, 1, 0, 0); chk_ir("w1", 8'h02, 8'hFF);
        chk("wrap.addr", {24'd0, bus.imem_addr}, 32'h00);
        step(0, 1, 0, 0); chk_ir("w2", 8'h03, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 0); chk_ir("halt", 8'hFF, 8'h05);
        chk("halt.halted", {31'd0, bus.halted}, 32'd1);
        chk("halt.addr", {24'd0, bus.imem_addr}, 32'h05);
        step(0, 1, 0, 0);
        chk("halt.drained", {31'd0, bus.ir_valid}, 32'd0);
        step(1, 1, 0, 0);
        chk("halt.start_ignored", {31'd0, bus.halted}, 32'd1);
        step(0, 1, 1, 8'h00);
        chk("unhalt", {31'd0, bus.halted}, 32'd0);
        step(0, 1, 0, 0); chk_ir("resume", 8'h03, 8'h00);

        // Async reset mid-stall, between edges
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.valid", {31'd0, bus.ir_valid}, 32'd0);
        chk("arst.halted", {31'd0, bus.halted}, 32'd0);
        chk("arst.addr", {24'd0, bus.imem_addr}, 32'h00);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("arst.idle", {31'd0, bus.ir_valid}, 32'd0);

        // Random traffic with occasional halts, redirects and starts
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0), 8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 8-bit microprocessor, sitting directly upstream of the instruction memory and downstream of nothing but control. Owns the program counter, drives the memory's combinational read address, and registers each returned instruction, tagged with its PC, into an instruction register. The decoder consumes that register through a valid/ready handshake. Supports PC redirect (branch/jump) and stops fetching on a halt opcode.

## Interface

Parameters:
- ADDR_W, 8, PC and memory address width.
- DATA_W, 8, instruction width.
- RESET_PC, 8'h00, PC value after reset.
- HALT_OP, 8'hFF, opcode that stops fetching.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching from the current PC; honoured only in IDLE.
- imem_addr  out  ADDR_W  read address to instruction memory; equals PC.
- imem_data  in  DATA_W  combinational read data from instruction memory.
- ir  out  DATA_W  registered instruction.
- ir_pc  out  ADDR_W  address `ir` was fetched from.
- ir_valid  out  1  `ir`/`ir_pc` hold an unconsumed instruction.
- ir_ready  in  1  decoder accepts `ir` this cycle.
- redirect  in  1  load `redirect_pc` and flush the instruction register.
- redirect_pc  in  ADDR_W  redirect target.
- halted  out  1  fetch stopped on HALT_OP.

## Operation

- Reset values: pc=RESET_PC, so imem_addr=RESET_PC; ir=0, ir_pc=0, ir_valid=0, halted=0, state IDLE.
- States:
  - IDLE: no fetch. start=1 moves to FETCH.
  - FETCH: fetch when the slot is free. The slot is free when ir_valid=0 or ir_ready=1.
  - HALT: no fetch; halted=1.
- Transfer: an instruction is transferred on any edge with ir_valid=1 and ir_ready=1.
- Fetch in FETCH with a free slot:
  - ir<=imem_data, ir_pc<=pc, ir_valid<=1.
  - If imem_data != HALT_OP: pc<=pc+1, modulo 2^ADDR_W, so 8'hFF wraps to 8'h00.
  - If imem_data == HALT_OP: pc unchanged, go to HALT, halted<=1 on the same edge.
- Slot not free (ir_valid=1 and ir_ready=0): ir, ir_pc, pc and imem_addr all hold. No instruction is skipped or duplicated.
- Slot drained with no fetch (IDLE or HALT, ir_valid=1, ir_ready=1): ir_valid<=0. ir and ir_pc keep their stale values.
- redirect has the highest priority:
  - pc<=redirect_pc and ir_valid<=0, overriding any fetch that edge.
  - A transfer on the same edge still counts as consumed.
  - From FETCH or HALT: go to FETCH, halted<=0.
  - In IDLE: pc is loaded and the state stays IDLE.
- start outside IDLE: ignored.
- Redirect to an address holding HALT_OP: that opcode is fetched and the unit halts normally.
- halted clears only on redirect or reset.

## Timing

- start sampled at edge N: FETCH from edge N; first ir_valid=1 at edge N+1 with ir=mem[pc].
- Throughput: one instruction per cycle while ir_ready=1.
- Redirect at edge R: ir_valid=0 after R and imem_addr=redirect_pc. ir=mem[redirect_pc] and ir_valid=1 after edge R+1 (bubble of one cycle).
- imem_addr is a register output with no combinational path from inputs.
- ir_valid must not depend combinationally on ir_ready.
- rst_n low at any time, including mid-stall or mid-redirect: all outputs take their reset values immediately, without waiting for a clock edge.

## Structure

- Shared package cpu_pkg holds:
  - ADDR_W, DATA_W, HALT_OP constants.
  - fetch_state_t enum {IDLE, FETCH, HALT}.
- One sub-module is natural: pc_reg, the PC register with increment, redirect-load, hold and async reset.
- The FSM and the instruction register live in fetch_unit.

## Test plan

- Reset, then start, with mem[0..3]=8'h11,22,33,44 and ir_ready=1: ir=11,22,33,44 on consecutive cycles, ir_pc=00,01,02,03, first ir_valid one edge after start.
- Hold ir_ready=0 for 3 cycles while ir=8'h22: ir, ir_pc=01 and imem_addr=02 stay stable. After release, the next ir is 33 with nothing skipped or duplicated.
- Redirect to 8'h80 while ir_valid=1 and ir_ready=0: next cycle ir_valid=0 and imem_addr=80. Following cycle ir=mem[80], ir_pc=80.
- Redirect to 8'hFE with mem[FE]=01, mem[FF]=02, mem[00]=03: ir_pc sequence FE, FF, 00; imem_addr wraps to 00.
- mem[05]=HALT_OP: ir=FF and ir_pc=05 with halted=1 on the same edge. imem_addr stays 05 and ir_valid drops after consumption. A later redirect to 00 clears halted and fetching resumes.
- Assert rst_n low mid-stream between edges: ir_valid=0, halted=0 and imem_addr=RESET_PC immediately. After release, the unit stays IDLE until start.
